// File: rtl/ext_sram_ctrl.sv
// External async SRAM controller on a 16-bit multiplexed address/data bus.
// Each transaction is: low address latch, high address latch, data phase with optional wait states.
module ext_sram_ctrl #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        rw,
    input  logic [31:0] addri,
    input  logic [15:0] dtw,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        doe,
    output logic        ale0,
    output logic        ale1,
    output logic        ce_n,
    output logic        oe_n,
    output logic        we_n,
    output logic [15:0] dtr,
    output logic        rdy
);

    typedef enum logic [1:0] {
        PH_LO   = 2'd0,
        PH_HI   = 2'd1,
        PH_DATA = 2'd2
    } phase_t;

    localparam logic [2:0] LP_WS   = 3'(WAIT_STATES);
    localparam logic       LP_HOLD = (WAIT_STATES != 0);

    phase_t      r_phase;
    phase_t      w_phase_nxt;
    logic [2:0]  r_wcnt;
    logic [2:0]  w_wcnt_nxt;
    logic [15:0] r_dtr;
    logic        w_last;

    assign w_last = (r_phase == PH_DATA) && (r_wcnt == LP_WS);
    assign dtr    = r_dtr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= PH_LO;
            r_wcnt  <= 3'd0;
        end else begin
            r_phase <= w_phase_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_dtr <= 16'd0;
        else if (valid && !rw && w_last)
            r_dtr <= din;
    end

    // Dropping valid at any edge aborts and rewinds to the low-address phase.
    always_comb begin
        w_phase_nxt = PH_LO;
        w_wcnt_nxt  = 3'd0;
        if (valid) begin
            case (r_phase)
                PH_LO:   w_phase_nxt = PH_HI;
                PH_HI:   w_phase_nxt = PH_DATA;
                PH_DATA: begin
                    if (!w_last) begin
                        w_phase_nxt = PH_DATA;
                        w_wcnt_nxt  = r_wcnt + 3'd1;
                    end
                end
                default: w_phase_nxt = PH_LO;
            endcase
        end
    end

    always_comb begin
        dout = 16'd0;
        doe  = 1'b0;
        ale0 = 1'b0;
        ale1 = 1'b0;
        ce_n = 1'b1;
        oe_n = 1'b1;
        we_n = 1'b1;
        rdy  = 1'b0;
        if (!reset && valid) begin
            case (r_phase)
                PH_LO: begin
                    dout = addri[15:0];
                    doe  = 1'b1;
                    ale0 = 1'b1;
                end
                PH_HI: begin
                    dout = addri[31:16];
                    doe  = 1'b1;
                    ale1 = 1'b1;
                end
                PH_DATA: begin
                    ce_n = 1'b0;
                    rdy  = w_last;
                    if (rw) begin
                        doe  = 1'b1;
                        dout = dtw;
                        // Release we_n one cycle early to give data hold time.
                        we_n = w_last && LP_HOLD;
                    end else begin
                        oe_n = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// Directed bench for ext_sram_ctrl: zero-wait and two-wait-state instances
// share one stimulus stream.
module tb_ext_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        rw;
    logic [31:0] addri;
    logic [15:0] dtw;
    logic [15:0] din;

    logic [15:0] dout0, dtr0, dout2, dtr2;
    logic doe0, ale00, ale10, ce_n0, oe_n0, we_n0, rdy0;
    logic doe2, ale02, ale12, ce_n2, oe_n2, we_n2, rdy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ext_sram_ctrl #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .valid(valid), .rw(rw),
        .addri(addri), .dtw(dtw), .din(din),
        .dout(dout0), .doe(doe0), .ale0(ale00), .ale1(ale10),
        .ce_n(ce_n0), .oe_n(oe_n0), .we_n(we_n0),
        .dtr(dtr0), .rdy(rdy0)
    );

    ext_sram_ctrl #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(reset), .valid(valid), .rw(rw),
        .addri(addri), .dtw(dtw), .din(din),
        .dout(dout2), .doe(doe2), .ale0(ale02), .ale1(ale12),
        .ce_n(ce_n2), .oe_n(oe_n2), .we_n(we_n2),
        .dtr(dtr2), .rdy(rdy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs the control outputs: {doe,ale0,ale1,ce_n,oe_n,we_n,rdy}
    function automatic logic [31:0] ctl0();
        return {25'd0, doe0, ale00, ale10, ce_n0, oe_n0, we_n0, rdy0};
    endfunction

    function automatic logic [31:0] ctl2();
        return {25'd0, doe2, ale02, ale12, ce_n2, oe_n2, we_n2, rdy2};
    endfunction

    localparam logic [31:0] IDLE = 32'b0001110;

    initial begin
        logic [4:0] rdy_exp;
        logic [4:0] oe_exp;
        logic [4:0] we_exp;
        reset = 1'b1; valid = 1'b0; rw = 1'b0;
        addri = 32'd0; dtw = 16'd0; din = 16'd0;
        #2;
        valid = 1'b1;
        #1;
        chk("rst_idle_ctl", ctl0(), IDLE);
        chk("rst_idle_dout", {16'd0, dout0}, 32'd0);
        valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("idle_ctl", ctl0(), IDLE);
        chk("idle_dtr", {16'd0, dtr0}, 32'd0);

        // zero-wait read of all-ones address
        valid = 1'b1; rw = 1'b0; addri = 32'hFFFFFFFF; din = 16'h0000;
        #1;
        chk("rd_c1_dout", {16'd0, dout0}, 32'hFFFF);
        chk("rd_c1_ctl", ctl0(), 32'b1101110);
        tick();
        chk("rd_c2_dout", {16'd0, dout0}, 32'hFFFF);
        chk("rd_c2_ctl", ctl0(), 32'b1011110);
        tick();
        din = 16'hFFFF;
        #1;
        chk("rd_c3_ctl", ctl0(), 32'b0000011);
        chk("rd_c3_dout", {16'd0, dout0}, 32'd0);
        tick();
        valid = 1'b0; din = 16'h0000;
        #1;
        chk("rd_dtr", {16'd0, dtr0}, 32'hFFFF);
        tick();

        // zero-wait write
        valid = 1'b1; rw = 1'b1; addri = 32'h12345678; dtw = 16'hABCD;
        #1;
        chk("wr_c1_dout", {16'd0, dout0}, 32'h5678);
        chk("wr_c1_ctl", ctl0(), 32'b1101110);
        tick();
        chk("wr_c2_dout", {16'd0, dout0}, 32'h1234);
        chk("wr_c2_ctl", ctl0(), 32'b1011110);
        tick();
        chk("wr_c3_dout", {16'd0, dout0}, 32'hABCD);
        chk("wr_c3_ctl", ctl0(), 32'b1000101);
        tick();
        valid = 1'b0;
        #1;
        chk("wr_dtr_kept", {16'd0, dtr0}, 32'hFFFF);
        tick();

        // abort after two cycles, then a fresh read
        valid = 1'b1; rw = 1'b0; addri = 32'h00000000; din = 16'h1111;
        tick();
        tick();
        valid = 1'b0;
        #1;
        chk("abort_idle", ctl0(), IDLE);
        tick();
        valid = 1'b1; addri = 32'h0000AAAA;
        #1;
        chk("ab_c1_dout", {16'd0, dout0}, 32'hAAAA);
        chk("ab_c1_ctl", ctl0(), 32'b1101110);
        chk("ab_dtr_kept", {16'd0, dtr0}, 32'hFFFF);
        tick();
        chk("ab_c2_dout", {16'd0, dout0}, 32'h0000);
        tick();
        din = 16'h5A5A;
        #1;
        chk("ab_c3_rdy", {31'd0, rdy0}, 32'd1);
        tick();
        // valid held: back-to-back read starts at once
        addri = 32'h00C0FFEE; din = 16'h0000;
        #1;
        chk("ab_dtr", {16'd0, dtr0}, 32'h5A5A);
        chk("b2b_c1_ctl", ctl0(), 32'b1101110);
        chk("b2b_c1_dout", {16'd0, dout0}, 32'hFFEE);
        tick();
        valid = 1'b0;
        tick();

        // ten alternating transactions with idle gaps
        for (int i = 0; i < 10; i++) begin
            int  n;
            bit  got;
            logic [15:0] pat;
            pat   = 16'(16'h1000 + i * 16'h0111);
            valid = 1'b1; rw = i[0];
            addri = {16'(i), pat}; dtw = ~pat; din = pat;
            got = 1'b0; n = 0;
            for (int c = 1; c <= 8 && !got; c++) begin
                #1;
                chk("alt_overlap", {31'd0, doe0 & ~oe_n0}, 32'd0);
                if (rdy0) begin
                    got = 1'b1;
                    n   = c;
                end else begin
                    tick();
                end
            end
            chk("alt_latency", n, 3);
            tick();
            valid = 1'b0;
            #1;
            if (!rw)
                chk("alt_rd_dtr", {16'd0, dtr0}, {16'd0, pat});
            tick();
        end

        // two wait states: read, cycle-by-cycle
        rdy_exp = 5'b10000;
        oe_exp  = 5'b00011;
        valid = 1'b1; rw = 1'b0; addri = 32'h00010002; din = 16'h0BAD;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) din = 16'h1357;
            #1;
            chk("ws2_rd_rdy", {31'd0, rdy2}, {31'd0, rdy_exp[c]});
            chk("ws2_rd_oe_n", {31'd0, oe_n2}, {31'd0, oe_exp[c]});
            tick();
        end
        valid = 1'b0; din = 16'h0000;
        #1;
        chk("ws2_rd_dtr", {16'd0, dtr2}, 32'h1357);
        tick();

        // two wait states: write, we_n released in last cycle
        we_exp = 5'b10011;
        valid = 1'b1; rw = 1'b1; dtw = 16'h2468;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("ws2_wr_we_n", {31'd0, we_n2}, {31'd0, we_exp[c]});
            chk("ws2_wr_rdy", {31'd0, rdy2}, {31'd0, rdy_exp[c]});
            tick();
        end
        valid = 1'b0;
        #1;
        chk("ws2_wr_dtr_kept", {16'd0, dtr2}, 32'h1357);
        tick();

        // reset during the data phase
        valid = 1'b1; rw = 1'b0;
        tick();
        tick();
        tick();
        #1;
        chk("ws2_mid_ce", {31'd0, ce_n2}, 32'd0);
        reset = 1'b1;
        #1;
        chk("ws2_rst_idle", ctl2(), IDLE);
        chk("ws2_rst_dtr", {16'd0, dtr2}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("ws2_post_rst", ctl2(), 32'b1101110);
        valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
